// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bundle between the two requesters (A: ALU, B: load unit) and the
// register-file write port, including the outstanding-write pending mask.
interface regfile_wr_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [AW-1:0]     a_addr;
  logic [DW-1:0]     a_data;
  logic              b_valid;
  logic              b_ready;
  logic [AW-1:0]     b_addr;
  logic [DW-1:0]     b_data;
  logic              rf_we;
  logic [AW-1:0]     rf_wR;
  logic [DW-1:0]     rf_wD;
  logic [(1<<AW)-1:0] pend_mask;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_we, rf_wR, rf_wD, pend_mask
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_we, rf_wR, rf_wD, pend_mask
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two one-entry writeback holding registers drained oldest-first onto the
// single register-file write port; exports a per-register pending mask.
module regfile_wr_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input logic                   clk,
  input logic                   reset,
  regfile_wr_arbiter_if.slave   wr_io
);
  localparam int unsigned NumRegs = 1 << AW;

  logic          a_full_q, a_full_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          b_full_q, b_full_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic          b_older_q, b_older_d;

  logic a_grant, b_grant;
  logic a_cap, b_cap;

  // Grants depend on registered state only, so ready never depends on valid.
  assign a_grant = a_full_q & (~b_full_q | ~b_older_q);
  assign b_grant = b_full_q & (~a_full_q | b_older_q);

  assign wr_io.a_ready = ~a_full_q | a_grant;
  assign wr_io.b_ready = ~b_full_q | b_grant;

  // Writes to x0 complete the handshake but are never held.
  assign a_cap = wr_io.a_valid & wr_io.a_ready & (wr_io.a_addr != '0);
  assign b_cap = wr_io.b_valid & wr_io.b_ready & (wr_io.b_addr != '0);

  always_comb begin
    a_full_d  = a_full_q;
    a_addr_d  = a_addr_q;
    a_data_d  = a_data_q;
    b_full_d  = b_full_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    b_older_d = b_older_q;

    if (a_grant) a_full_d = 1'b0;
    if (b_grant) b_full_d = 1'b0;
    if (a_cap) begin
      a_full_d = 1'b1;
      a_addr_d = wr_io.a_addr;
      a_data_d = wr_io.a_data;
    end
    if (b_cap) begin
      b_full_d = 1'b1;
      b_addr_d = wr_io.b_addr;
      b_data_d = wr_io.b_data;
    end

    // With both held, the entry that was not just captured is the older one;
    // a same-edge capture of both makes A older.
    if (a_full_d && b_full_d) begin
      if (a_cap && b_cap)  b_older_d = 1'b0;
      else if (a_cap)      b_older_d = 1'b1;
      else if (b_cap)      b_older_d = 1'b0;
    end else begin
      b_older_d = b_full_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_full_q  <= 1'b0;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      b_full_q  <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      b_older_q <= 1'b0;
    end else begin
      a_full_q  <= a_full_d;
      a_addr_q  <= a_addr_d;
      a_data_q  <= a_data_d;
      b_full_q  <= b_full_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      b_older_q <= b_older_d;
    end
  end

  logic [NumRegs-1:0] pend;

  always_comb begin
    wr_io.rf_we = a_full_q | b_full_q;
    wr_io.rf_wR = '0;
    wr_io.rf_wD = '0;
    if (a_grant) begin
      wr_io.rf_wR = a_addr_q;
      wr_io.rf_wD = a_data_q;
    end else if (b_grant) begin
      wr_io.rf_wR = b_addr_q;
      wr_io.rf_wD = b_data_q;
    end

    pend = '0;
    if (a_full_q) pend[a_addr_q] = 1'b1;
    if (b_full_q) pend[b_addr_q] = 1'b1;
  end

  assign wr_io.pend_mask = pend;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single write, x0 drop,
// same-edge contention, same-register ordering, streaming and mid-queue reset.
module tb_regfile_wr_arbiter;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  regfile_wr_arbiter_if #(.DW(32), .AW(5)) bus ();

  regfile_wr_arbiter #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .wr_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.a_addr  = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_addr  = '0;
    bus.b_data  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    vectors++;
    if (bus.rf_we !== 1'b0 || bus.rf_wR !== 5'd0 || bus.rf_wD !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_port: we=%b wR=%0d wD=%h want 0/0/0", bus.rf_we, bus.rf_wR, bus.rf_wD);
    end
    vectors++;
    if (bus.pend_mask !== 32'd0 || bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: pend=%h a_rdy=%b b_rdy=%b want 0/1/1",
               bus.pend_mask, bus.a_ready, bus.b_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_write();
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd3;
    bus.a_data  = 32'hDEADBEEF;
    vectors++;
    if (bus.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 1", bus.a_ready);
    end
    tick();
    idle_inputs();
    vectors++;
    if (bus.rf_we !== 1'b1 || bus.rf_wR !== 5'd3 || bus.rf_wD !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_write: we=%b wR=%0d wD=%h want 1/3/deadbeef",
               bus.rf_we, bus.rf_wR, bus.rf_wD);
    end
    vectors++;
    if (bus.pend_mask !== 32'h8) begin
      miscompares++;
      $display("FAIL single_pend: got %h want 00000008", bus.pend_mask);
    end
    tick();
    vectors++;
    if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0) begin
      miscompares++;
      $display("FAIL single_drain: we=%b pend=%h want 0/0", bus.rf_we, bus.pend_mask);
    end
  endtask

  task automatic test_x0_drop();
    bus.b_valid = 1'b1;
    bus.b_addr  = 5'd0;
    bus.b_data  = 32'h12345678;
    tick();
    idle_inputs();
    vectors++;
    if (bus.b_ready !== 1'b1 || bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_drop: b_rdy=%b we=%b pend=%h want 1/0/0",
               bus.b_ready, bus.rf_we, bus.pend_mask);
    end
    tick();
    vectors++;
    if (bus.rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_later: we=%b want 0", bus.rf_we);
    end
  endtask

  task automatic test_contention();
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'd1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'd2;
    tick();
    idle_inputs();
    vectors++;
    if (bus.rf_we !== 1'b1 || bus.rf_wR !== 5'd7 || bus.rf_wD !== 32'd1) begin
      miscompares++;
      $display("FAIL contend_c1: we=%b wR=%0d wD=%h want 1/7/1", bus.rf_we, bus.rf_wR, bus.rf_wD);
    end
    vectors++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || bus.pend_mask !== 32'h280) begin
      miscompares++;
      $display("FAIL contend_c1_state: a_rdy=%b b_rdy=%b pend=%h want 1/0/00000280",
               bus.a_ready, bus.b_ready, bus.pend_mask);
    end
    tick();
    vectors++;
    if (bus.rf_we !== 1'b1 || bus.rf_wR !== 5'd9 || bus.rf_wD !== 32'd2) begin
      miscompares++;
      $display("FAIL contend_c2: we=%b wR=%0d wD=%h want 1/9/2", bus.rf_we, bus.rf_wR, bus.rf_wD);
    end
    tick();
    vectors++;
    if (bus.rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL contend_drain: we=%b want 0", bus.rf_we);
    end
  endtask

  // B's x10 is held behind an older A entry; A's later x10 must retire after it.
  task automatic test_same_reg_order();
    logic [31:0] last_x10;
    last_x10 = 32'd0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd5;  bus.a_data = 32'h55;
    bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 32'hAA;
    tick();
    bus.b_valid = 1'b0;
    bus.a_addr  = 5'd10;
    bus.a_data  = 32'hBB;
    vectors++;
    if (bus.rf_wR !== 5'd5 || bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL order_c1: wR=%0d a_rdy=%b b_rdy=%b want 5/1/0",
               bus.rf_wR, bus.a_ready, bus.b_ready);
    end
    tick();
    idle_inputs();
    vectors++;
    if (bus.rf_we !== 1'b1 || bus.rf_wR !== 5'd10 || bus.rf_wD !== 32'hAA) begin
      miscompares++;
      $display("FAIL order_c2: we=%b wR=%0d wD=%h want 1/10/aa", bus.rf_we, bus.rf_wR, bus.rf_wD);
    end
    vectors++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1 || bus.pend_mask !== 32'h400) begin
      miscompares++;
      $display("FAIL order_c2_state: a_rdy=%b b_rdy=%b pend=%h want 0/1/00000400",
               bus.a_ready, bus.b_ready, bus.pend_mask);
    end
    if (bus.rf_we && bus.rf_wR == 5'd10) last_x10 = bus.rf_wD;
    tick();
    vectors++;
    if (bus.rf_we !== 1'b1 || bus.rf_wR !== 5'd10 || bus.rf_wD !== 32'hBB) begin
      miscompares++;
      $display("FAIL order_c3: we=%b wR=%0d wD=%h want 1/10/bb", bus.rf_we, bus.rf_wR, bus.rf_wD);
    end
    if (bus.rf_we && bus.rf_wR == 5'd10) last_x10 = bus.rf_wD;
    tick();
    vectors++;
    if (bus.rf_we !== 1'b0 || last_x10 !== 32'hBB) begin
      miscompares++;
      $display("FAIL order_final: we=%b x10=%h want 0/bb", bus.rf_we, last_x10);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      bus.a_valid = 1'b1;
      bus.a_addr  = 5'(i);
      bus.a_data  = 32'(i * 32'h100);
      vectors++;
      if (bus.a_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.a_ready);
      end
      tick();
      vectors++;
      if (bus.rf_we !== 1'b1 || bus.rf_wR !== 5'(i) || bus.rf_wD !== 32'(i * 32'h100)) begin
        miscompares++;
        $display("FAIL stream_write[%0d]: we=%b wR=%0d wD=%h want 1/%0d/%h",
                 i, bus.rf_we, bus.rf_wR, bus.rf_wD, i, i * 32'h100);
      end
    end
    idle_inputs();
    tick();
    vectors++;
    if (bus.rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_drain: we=%b want 0", bus.rf_we);
    end
  endtask

  task automatic test_reset_mid_queue();
    int seen;
    seen = 0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd4; bus.a_data = 32'h44;
    bus.b_valid = 1'b1; bus.b_addr = 5'd5; bus.b_data = 32'h55;
    tick();
    idle_inputs();
    vectors++;
    if (bus.pend_mask !== 32'h30) begin
      miscompares++;
      $display("FAIL midq_filled: pend=%h want 00000030", bus.pend_mask);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0 || bus.a_ready !== 1'b1 ||
        bus.b_ready !== 1'b1 || bus.rf_wR !== 5'd0) begin
      miscompares++;
      $display("FAIL midq_reset: we=%b pend=%h a_rdy=%b b_rdy=%b wR=%0d want 0/0/1/1/0",
               bus.rf_we, bus.pend_mask, bus.a_ready, bus.b_ready, bus.rf_wR);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.rf_we) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midq_discard: %0d writes after reset, want 0", seen);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_write();
    test_x0_drop();
    test_contention();
    test_same_reg_order();
    test_back_to_back();
    test_reset_mid_queue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
